// File: rtl/uart_rx_fifo_if.sv
// Receive-side bundle of the UART receiver: FIFO read port, occupancy and sticky error flags.
// master is the receiver, slave is the downstream consumer.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int AW        = 4
) ();
    logic                 rd_en;
    logic                 err_clr;
    logic [DATA_BITS-1:0] data_out;
    logic                 empty;
    logic                 full;
    logic [AW:0]          count;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overflow;

    modport master (
        input  rd_en, err_clr,
        output data_out, empty, full, count, frame_err, parity_err, overflow
    );

    modport slave (
        output rd_en, err_clr,
        input  data_out, empty, full, count, frame_err, parity_err, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver: 16x oversampling with 3-sample majority vote,
// optional parity, sticky error flags and a show-ahead receive FIFO.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 4
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic [2:0]     baud_set,
    input  logic           Rs232_Rx,
    uart_rx_fifo_if.master rx
);
    localparam int CW = $clog2(CLK_FREQ / (9600 * 16));

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    function automatic logic [CW-1:0] div_of(input logic [2:0] b);
        case (b)
            3'd0:    return CW'(CLK_FREQ / (9600 * 16) - 1);
            3'd1:    return CW'(CLK_FREQ / (19200 * 16) - 1);
            3'd2:    return CW'(CLK_FREQ / (38400 * 16) - 1);
            3'd3:    return CW'(CLK_FREQ / (57600 * 16) - 1);
            default: return CW'(CLK_FREQ / (115200 * 16) - 1);
        endcase
    endfunction

    state_t               state, state_nx;
    logic                 rx_s1, rx_s2, rx_d;
    logic [2:0]           baud_q;
    logic [CW-1:0]        div_cnt;
    logic [3:0]           tick_cnt, bit_cnt;
    logic                 s7, s8, par_bit;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tick, tick9, tick15, maj, start_det, par_exp, par_bad;
    logic                 wr_req, set_fe, set_pe, set_ovf, do_wr, do_rd;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count_q;
    logic                 fe_q, pe_q, ovf_q;

    assign tick      = (div_cnt == div_of(baud_q));
    assign tick9     = tick && (tick_cnt == 4'd9);
    assign tick15    = tick && (tick_cnt == 4'd15);
    assign maj       = (s7 & s8) | (s7 & rx_s2) | (s8 & rx_s2);
    assign start_det = (state == S_IDLE) && rx_d && !rx_s2;
    assign par_exp   = (PARITY == 1) ? ~^shift_q : ^shift_q;
    assign par_bad   = (PARITY != 0) && (par_bit != par_exp);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        wr_req   = 1'b0;
        set_fe   = 1'b0;
        set_pe   = 1'b0;
        case (state)
            S_IDLE:  if (start_det) state_nx = S_START;
            S_START: begin
                if (tick9 && maj) state_nx = S_IDLE;
                else if (tick15)  state_nx = S_DATA;
            end
            S_DATA:  if (tick15 && bit_cnt == 4'(DATA_BITS - 1))
                         state_nx = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (tick15) state_nx = S_STOP;
            S_STOP:  begin
                // Commit mid-stop-bit so a following start edge is never missed.
                if (tick9) begin
                    state_nx = S_IDLE;
                    if (!maj)         set_fe = 1'b1;
                    else if (par_bad) set_pe = 1'b1;
                    else              wr_req = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            baud_q   <= 3'd0;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            s7       <= 1'b1;
            s8       <= 1'b1;
            par_bit  <= 1'b0;
            shift_q  <= '0;
        end else begin
            rx_s1 <= Rs232_Rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
            if (state == S_IDLE) baud_q <= baud_set;
            if (start_det) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (tick) begin
                div_cnt  <= '0;
                tick_cnt <= tick_cnt + 4'd1;
                if (tick_cnt == 4'd7) s7 <= rx_s2;
                if (tick_cnt == 4'd8) s8 <= rx_s2;
                if (tick_cnt == 4'd9 && state == S_DATA)
                    shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                if (tick_cnt == 4'd9 && state == S_PAR) par_bit <= maj;
                if (tick_cnt == 4'd15 && state == S_DATA) bit_cnt <= bit_cnt + 4'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // A read in the commit cycle frees a slot, so a full FIFO still accepts.
    assign do_rd   = rx.rd_en && !rx.empty;
    assign do_wr   = wr_req && (!rx.full || do_rd);
    assign set_ovf = wr_req && rx.full && !do_rd;

    always_ff @(posedge Clk) begin
        if (do_wr) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            fe_q  <= set_fe  | (fe_q  & ~rx.err_clr);
            pe_q  <= set_pe  | (pe_q  & ~rx.err_clr);
            ovf_q <= set_ovf | (ovf_q & ~rx.err_clr);
        end
    end

    assign rx.empty      = (count_q == '0);
    assign rx.full       = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign rx.count      = count_q;
    assign rx.data_out   = rx.empty ? '0 : mem[rd_ptr];
    assign rx.frame_err  = fe_q;
    assign rx.parity_err = pe_q;
    assign rx.overflow   = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: dut A is 8N1 with a 4-deep FIFO, dut B is 8E1 with a 16-deep FIFO.
module tb_uart_rx_fifo;
    localparam int BIT_CLKS = 432;   // 16 ticks x 27 clocks at 115200 baud

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [2:0] baud_set;
    logic       rxA, rxB;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] qA[$];
    logic [7:0] qB[$];

    uart_rx_fifo_if #(.DATA_BITS(8), .AW(2)) ifA ();
    uart_rx_fifo_if #(.DATA_BITS(8), .AW(4)) ifB ();

    uart_rx_fifo #(.CLK_FREQ(50000000), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4), .AW(2)) dutA (
        .Clk(Clk), .Rst_n(Rst_n), .baud_set(baud_set), .Rs232_Rx(rxA), .rx(ifA));
    uart_rx_fifo #(.CLK_FREQ(50000000), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16), .AW(4)) dutB (
        .Clk(Clk), .Rst_n(Rst_n), .baud_set(baud_set), .Rs232_Rx(rxB), .rx(ifB));

    always #10 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] fr8(input logic [7:0] d, input logic stop);
        return {1'b1, stop, d, 1'b0};
    endfunction

    function automatic logic [10:0] fr9(input logic [7:0] d, input logic p, input logic stop);
        return {stop, p, d, 1'b0};
    endfunction

    // Negedge offset (from the start-bit fall) of the cycle in which stop tick 9 commits.
    function automatic int commit_at(input int nb);
        return 29 + 27 * ((nb - 1) * 16 + 9);
    endfunction

    task automatic send(input bit d, input logic [10:0] bits, input int nb,
                        input int rd_at, input int clr_at, input int spike_at);
        logic lv;
        for (int c = 0; c < nb * BIT_CLKS; c++) begin
            @(negedge Clk);
            lv = bits[c / BIT_CLKS];
            if (c == spike_at) lv = 1'b0;
            if (d) begin
                rxB = lv;
                ifB.err_clr = (c == clr_at);
            end else begin
                rxA = lv;
                ifA.rd_en   = (c == rd_at);
                ifA.err_clr = (c == clr_at);
            end
        end
        @(negedge Clk);
        rxA = 1'b1; rxB = 1'b1;
        ifA.rd_en = 1'b0; ifA.err_clr = 1'b0; ifB.err_clr = 1'b0;
        repeat (100) @(negedge Clk);
    endtask

    task automatic popA(input string tag);
        logic [7:0] e;
        e = qA.pop_front();
        chk(tag, 32'(ifA.data_out), 32'(e));
        @(negedge Clk) ifA.rd_en = 1'b1;
        @(negedge Clk) ifA.rd_en = 1'b0;
    endtask

    task automatic clrA();
        @(negedge Clk) ifA.err_clr = 1'b1;
        @(negedge Clk) ifA.err_clr = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0; baud_set = 3'd4; rxA = 1'b1; rxB = 1'b1;
        ifA.rd_en = 1'b0; ifA.err_clr = 1'b0; ifB.rd_en = 1'b0; ifB.err_clr = 1'b0;
        repeat (5) @(negedge Clk);
        chk("rst_empty", 32'(ifA.empty), 32'd1);
        chk("rst_full",  32'(ifA.full),  32'd0);
        chk("rst_count", 32'(ifA.count), 32'd0);
        chk("rst_data",  32'(ifA.data_out), 32'd0);
        chk("rst_flags", 32'({ifA.frame_err, ifA.parity_err, ifA.overflow}), 32'd0);
        Rst_n = 1'b1;
        repeat (10) @(negedge Clk);

        // two good frames, show-ahead head order
        send(0, fr8(8'h55, 1'b1), 10, -1, -1, -1); qA.push_back(8'h55);
        send(0, fr8(8'hA3, 1'b1), 10, -1, -1, -1); qA.push_back(8'hA3);
        chk("t1_count", 32'(ifA.count), 32'(qA.size()));
        popA("t1_head0");
        popA("t1_head1");
        chk("t1_empty", 32'(ifA.empty), 32'd1);

        // half-bit glitch is a false start
        @(negedge Clk) rxA = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge Clk);
        rxA = 1'b1;
        repeat (600) @(negedge Clk);
        chk("t2_count", 32'(ifA.count), 32'd0);
        chk("t2_flags", 32'({ifA.frame_err, ifA.parity_err, ifA.overflow}), 32'd0);

        // low stop bit, then a good frame after the line recovers
        send(0, fr8(8'h3C, 1'b0), 10, -1, -1, -1);
        chk("t4_fe",    32'(ifA.frame_err), 32'd1);
        chk("t4_count", 32'(ifA.count), 32'd0);
        send(0, fr8(8'h81, 1'b1), 10, -1, -1, -1); qA.push_back(8'h81);
        chk("t4_count2", 32'(ifA.count), 32'(qA.size()));
        popA("t4_head");
        clrA();
        chk("t4_fe_clr", 32'(ifA.frame_err), 32'd0);

        // fill past depth, then a commit coinciding with a read
        for (int i = 1; i <= 5; i++) begin
            send(0, fr8(8'(i), 1'b1), 10, -1, -1, -1);
            if (qA.size() < 4) qA.push_back(8'(i));
        end
        chk("t5_full",  32'(ifA.full), 32'd1);
        chk("t5_count", 32'(ifA.count), 32'd4);
        chk("t5_ovf",   32'(ifA.overflow), 32'd1);
        chk("t5_head",  32'(ifA.data_out), 32'(qA[0]));
        send(0, fr8(8'h06, 1'b1), 10, commit_at(10), -1, -1);
        void'(qA.pop_front()); qA.push_back(8'h06);
        chk("t5_count2", 32'(ifA.count), 32'd4);
        chk("t5_head2",  32'(ifA.data_out), 32'(qA[0]));
        for (int i = 0; i < 4; i++) popA("t5_drain");
        chk("t5_empty", 32'(ifA.empty), 32'd1);
        clrA();

        // single-cycle spike inside data bit 3 at its tick-8 sample
        send(0, fr8(8'hFF, 1'b1), 10, -1, -1, 27 + 27 * (4 * 16 + 8)); qA.push_back(8'hFF);
        chk("t6_count", 32'(ifA.count), 32'd1);
        chk("t6_head",  32'(ifA.data_out), 32'(qA[0]));
        send(0, fr8(8'h3C, 1'b0), 10, -1, -1, -1);
        chk("t6_fe", 32'(ifA.frame_err), 32'd1);
        send(0, fr8(8'h00, 1'b1), 3, -1, -1, -1);
        @(negedge Clk) Rst_n = 1'b0;
        @(negedge Clk);
        chk("t6_rst_empty", 32'(ifA.empty), 32'd1);
        chk("t6_rst_count", 32'(ifA.count), 32'd0);
        chk("t6_rst_flags", 32'({ifA.frame_err, ifA.parity_err, ifA.overflow}), 32'd0);
        qA.delete();
        Rst_n = 1'b1;
        repeat (10) @(negedge Clk);

        // even parity: 0x07 needs parity bit 1
        send(1, fr9(8'h07, 1'b0, 1'b1), 11, -1, -1, -1);
        chk("t3_pe",    32'(ifB.parity_err), 32'd1);
        chk("t3_count", 32'(ifB.count), 32'd0);
        @(negedge Clk) ifB.err_clr = 1'b1;
        @(negedge Clk) ifB.err_clr = 1'b0;
        chk("t3_pe_clr", 32'(ifB.parity_err), 32'd0);
        send(1, fr9(8'h07, 1'b1, 1'b1), 11, -1, -1, -1); qB.push_back(8'h07);
        chk("t3_count2", 32'(ifB.count), 32'(qB.size()));
        chk("t3_head",   32'(ifB.data_out), 32'(qB[0]));
        chk("t3_pe_ok",  32'(ifB.parity_err), 32'd0);
        send(1, fr9(8'h07, 1'b0, 1'b1), 11, -1, commit_at(11), -1);
        chk("t3_set_wins", 32'(ifB.parity_err), 32'd1);
        chk("t3_count3",   32'(ifB.count), 32'(qB.size()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, successor to the fixed 8N1 byte receiver. Adds configurable data width and parity, 16x oversampling with 3-sample majority vote, false-start rejection, frame/parity/overflow error flags, and a show-ahead receive FIFO. Sits between the Rs232_Rx pad and downstream consumers (probe/debug logic, command parsers), replacing the top-level Rx_Done plus capture-register pattern.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
DATA_BITS, 8, payload bits per frame; legal range 5 to 9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
FIFO_DEPTH, 16, FIFO entry count; must be a power of 2 and at least 2.
AW, 4, FIFO address width; equals log2(FIFO_DEPTH).

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
baud_set  in  3  0:9600 1:19200 2:38400 3:57600 4..7:115200
Rs232_Rx  in  1  asynchronous serial input; idle level is high
rd_en  in  1  pops the FIFO head; ignored when empty
err_clr  in  1  single-cycle pulse that clears all sticky error flags
data_out  out  DATA_BITS  FIFO head; valid while empty=0
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  AW+1  FIFO occupancy, 0 to FIFO_DEPTH
frame_err  out  1  sticky: a stop bit was sampled low
parity_err  out  1  sticky: a parity mismatch was detected
overflow  out  1  sticky: a frame was dropped because the FIFO was full

Behaviour:
- Reset (async, Rst_n=0): FSM goes to IDLE; all counters cleared; empty=1, full=0, count=0, data_out=0; all error flags cleared.
- Input path: Rs232_Rx passes through a 2-flop synchroniser plus one history flop. A start is detected on a 1->0 transition of the synchronised signal.
- Tick generator: divider DIV = CLK_FREQ/(baud*16) - 1, integer truncation, from a constant table. It produces a one-cycle tick every DIV+1 clocks. The generator is reset on start detect. baud_set is latched only in IDLE; changes mid-frame have no effect.
- Bit timing: each bit spans 16 ticks. The bit value is the majority of samples taken at ticks 7, 8 and 9.
- FSM states: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
  - IDLE: wait for start detect.
  - START: if the majority is 1, the start is false; return to IDLE, no flags set.
  - DATA: shift DATA_BITS bits, LSB first.
  - PARITY: compare the received bit with the computed parity (odd or even).
  - STOP: evaluate the majority at tick 9, then return to IDLE at that point, not at tick 15, so back-to-back frames are tolerated.
- Frame commit at STOP tick 9:
  - Stop bit = 0: set frame_err; discard the frame; no FIFO write. Return to IDLE. A new start is detected only after the line returns high.
  - Stop bit = 1 and parity bad: set parity_err; discard the frame.
  - Good frame: write to the FIFO. If full is high and rd_en is not asserted in the same cycle, drop the frame and set overflow.
- FIFO: synchronous, show-ahead. data_out always reflects the head entry.
  - rd_en while empty is ignored.
  - Simultaneous write and read: count is unchanged, both pointers advance; legal even when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - full = (count==FIFO_DEPTH); empty = (count==0).
- Error flags: once set they stay set until err_clr. If err_clr coincides with a new error event, the set wins.
- Latency: the FIFO entry becomes visible (empty falls) one clock after STOP tick 9.
- Reset mid-frame: the partial frame is discarded and the FIFO is cleared.

Test Plan:
1. CLK_FREQ=50e6, baud_set=4 (DIV=26), 8N1, send 0x55 then 0xA3 -> count=2, data_out=0x55; after one rd_en pulse, data_out=0xA3.
2. 0.5-bit low glitch on Rs232_Rx in IDLE -> no FIFO write, no flags set, FSM back in IDLE.
3. PARITY=2, send 0x07 with parity bit 0 (correct value is 1) -> parity_err=1, count=0. Then pulse err_clr -> parity_err=0.
4. Send 0x3C with stop bit forced low -> frame_err=1, no write. After the line returns high, send 0x81 -> count=1, data_out=0x81.
5. FIFO_DEPTH=4: send 5 frames 0x01..0x05 with no reads -> full=1, count=4, overflow=1, head=0x01. A 6th frame arriving with rd_en asserted at commit -> accepted, count stays 4.
6. Single-cycle spike on Rs232_Rx at data-bit tick 8 of 0xFF -> majority vote rejects it, received byte is 0xFF. Assert Rst_n=0 mid-frame -> empty=1, all flags 0.
